mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access pipeline stage. It consumes the M-stage load/store request registered by the execute stage (memFunc, addresses, store data, enables) and drives a 64-bit data-RAM port with a valid/ready request and a response handshake. It aligns store data to byte lanes and builds byte masks. It extracts and extends load data, stalls the pipeline while an access is outstanding, and registers the writeback (W) bundle that also serves as the forwarding source "rdWriteDataPre" for execute.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, RAM/register data width (fixed at 64; byte-lane logic assumes 8 lanes)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
memFuncM  in  11  one-hot op: [0]lb [1]lh [2]lw [3]ld [4]lbu [5]lhu [6]lwu [7]sb [8]sh [9]sw [10]sd
RamReadEnableM  in  1  load present in M
RamWriteEnableM  in  1  store present in M
RamReadAddrM  in  64  load byte address
RamWriteAddrM  in  64  store byte address
RamWriteDataM  in  64  store data, LSB-justified
rdWriteEnableM  in  1  rd write enable
rdWriteAddrM  in  5  rd index
rdWriteDataM  in  64  ALU result, used for non-loads
pcM  in  64  pc
instM  in  32  instruction
ram_req_valid  out  1  request valid
ram_req_ready  in  1  RAM accepts request
ram_req_we  out  1  1=write
ram_req_addr  out  64  8-byte-aligned address {addr[63:3],3'b0}
ram_req_wdata  out  64  lane-shifted store data
ram_req_wmask  out  8  byte-enable
ram_resp_valid  in  1  read data valid
ram_resp_rdata  in  64  aligned doubleword
stallM  out  1  freeze F/D/E/M pipeline registers
rdWriteEnableW  out  1  registered
rdWriteAddrW  out  5  registered
rdWriteDataW  out  64  registered writeback data
pcW  out  64  registered
instW  out  32  registered

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (rst). On reset, the state goes to IDLE and every output register is 0: ram_req_valid, ram_req_we, ram_req_addr, ram_req_wdata, ram_req_wmask, all *W outputs. stallM=0.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE: if RamReadEnableM|RamWriteEnableM, latch the request fields and go to REQ. Otherwise the W registers load the M inputs every cycle (rdWriteDataW=rdWriteDataM).
- REQ: ram_req_valid=1, and the request fields are held stable until ready. On valid&ready: a write goes to DONE; a read goes to RESP.
- RESP: wait for ram_resp_valid. On it, capture the extracted load data and go to DONE. resp_valid outside RESP is ignored.
- DONE: stallM=0. At the clock edge the W registers load, with rdWriteDataW = load data for a load and rdWriteDataM for a store. Then go to IDLE.
- stallM=1 in IDLE when a memory op is present, and in REQ and RESP. stallM=0 in DONE and in IDLE with no memory op.
- Minimum latency with ready=1 and resp_valid=1 immediately: a load enters M at cycle 0, REQ is cycle 1, RESP is cycle 2, DONE is cycle 3, and W is valid at cycle 4. A store with ready=1 reaches W at cycle 3.
- Store alignment: off=addr[2:0]. wdata=RamWriteDataM<<(8*off). Base masks are sb 8'h01, sh 8'h03, sw 8'h0F, sd 8'hFF, and the mask is base<<off (truncated to 8 bits).
- Load extraction: d=rdata>>(8*off). The low 8/16/32/64 bits are taken per op, sign-extended for lb/lh/lw and zero-extended for lbu/lhu/lwu.
- Multiple one-hot bits set: the lowest set bit wins.
- Simultaneous read and write enable: treated as a write.
- Reset in REQ or RESP: abandon the access, drop valid in the same edge, return to IDLE. A late response is ignored.
- Misaligned access without the optional feature: performed as-is. Bytes past lane 7 are dropped from the mask.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- When defined: an access is misaligned if (lh/lhu/sh and off[0]), (w-ops and off[1:0]!=0), or (d-ops and off!=0). A misaligned access issues no RAM request; the FSM goes IDLE to DONE with rdWriteEnableW forced to 0. A new output misalignW (1 bit, reset 0) is 1 for that W cycle.
- When undefined: no misalignW port and no check.

Decomposition:
- defines.v gets MEM_FUNC_BUS (10:0), the bit indices MEM_LB..MEM_SD, and the state encodings MEM_IDLE/REQ/RESP/DONE (2 bits).
- Combinational sub-module mem_align: store lane shift plus mask generation, and load extract plus extend.
- The existing gen_en_dff is used for the W registers.

Test Plan:
- sd addr 0x1000, data 0x1122334455667788, ready=1 -> one request cycle with addr 0x1000, mask 0xFF, wdata unchanged; stallM high 2 cycles.
- sb addr 0x1005, data 0xAB -> addr 0x1000, mask 0x20, wdata 0x0000AB0000000000.
- lb addr 0x1003, rdata 0x00000000F0000000 -> rdWriteDataW 0xFFFFFFFFFFFFFFF0. Same with lbu -> 0x00000000000000F0.
- lw addr 0x2004, ready held low 3 cycles, resp delayed 2 cycles -> valid/addr/we stable throughout; stallM held; W updates exactly once after DONE.
- rst asserted in RESP, then resp_valid arrives -> IDLE, all outputs 0, response ignored, no W update.
- With MEM_MISALIGN_TRAP_EN: lw addr 0x2002 -> no ram_req_valid; misalignW=1; rdWriteEnableW=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: memory-op bit indices, FSM state encoding and op-priority helper
package mem_stage_pkg;

    localparam int MEM_FUNC_W = 11;
    localparam int MEM_LB  = 0;
    localparam int MEM_LH  = 1;
    localparam int MEM_LW  = 2;
    localparam int MEM_LD  = 3;
    localparam int MEM_LBU = 4;
    localparam int MEM_LHU = 5;
    localparam int MEM_LWU = 6;
    localparam int MEM_SB  = 7;
    localparam int MEM_SH  = 8;
    localparam int MEM_SW  = 9;
    localparam int MEM_SD  = 10;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_RESP = 2'd2,
        MEM_DONE = 2'd3
    } mem_state_e;

    // Keep only the lowest set bit so a malformed one-hot op decodes deterministically
    function automatic logic [MEM_FUNC_W-1:0] lowest_set(input logic [MEM_FUNC_W-1:0] f);
        return f & (~f + 11'd1);
    endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: store byte-lane shift and mask, load lane extract and sign/zero extension
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [MEM_FUNC_W-1:0] i_func,
    input  logic [2:0]            i_off,
    input  logic [63:0]           i_wdata,
    input  logic [63:0]           i_rdata,
    output logic [63:0]           o_wdata,
    output logic [7:0]            o_wmask,
    output logic [63:0]           o_rdata
);

    logic [7:0]  w_base;
    logic [63:0] w_shr;

    assign o_wdata = i_wdata << {i_off, 3'b000};
    assign w_shr   = i_rdata >> {i_off, 3'b000};
    // Lanes beyond byte 7 fall off the 8-bit mask
    assign o_wmask = w_base << i_off;

    // Byte-enable pattern for the store size
    always_comb begin
        w_base = i_func[MEM_SB] ? 8'h01 :
                 i_func[MEM_SH] ? 8'h03 :
                 i_func[MEM_SW] ? 8'h0F :
                 i_func[MEM_SD] ? 8'hFF : 8'h00;
    end

    // Pick the low bytes of the shifted doubleword and extend per load type
    always_comb begin
        o_rdata = i_func[MEM_LB]  ? {{56{w_shr[7]}},  w_shr[7:0]}  :
                  i_func[MEM_LH]  ? {{48{w_shr[15]}}, w_shr[15:0]} :
                  i_func[MEM_LW]  ? {{32{w_shr[31]}}, w_shr[31:0]} :
                  i_func[MEM_LD]  ? w_shr :
                  i_func[MEM_LBU] ? {56'd0, w_shr[7:0]}  :
                  i_func[MEM_LHU] ? {48'd0, w_shr[15:0]} :
                  i_func[MEM_LWU] ? {32'd0, w_shr[31:0]} : 64'd0;
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: M-stage RAM access FSM with registered W bundle; MEM_MISALIGN_TRAP_EN enables misalignment trapping
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MEM_FUNC_W-1:0] memFuncM,
    input  logic                  RamReadEnableM,
    input  logic                  RamWriteEnableM,
    input  logic [ADDR_W-1:0]     RamReadAddrM,
    input  logic [ADDR_W-1:0]     RamWriteAddrM,
    input  logic [DATA_W-1:0]     RamWriteDataM,
    input  logic                  rdWriteEnableM,
    input  logic [4:0]            rdWriteAddrM,
    input  logic [DATA_W-1:0]     rdWriteDataM,
    input  logic [63:0]           pcM,
    input  logic [31:0]           instM,
    output logic                  ram_req_valid,
    input  logic                  ram_req_ready,
    output logic                  ram_req_we,
    output logic [ADDR_W-1:0]     ram_req_addr,
    output logic [DATA_W-1:0]     ram_req_wdata,
    output logic [7:0]            ram_req_wmask,
    input  logic                  ram_resp_valid,
    input  logic [DATA_W-1:0]     ram_resp_rdata,
    output logic                  stallM,
    output logic                  rdWriteEnableW,
    output logic [4:0]            rdWriteAddrW,
    output logic [DATA_W-1:0]     rdWriteDataW,
    output logic [63:0]           pcW,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                  misalignW,
`endif
    output logic [31:0]           instW
);

    mem_state_e              r_state;
    logic [MEM_FUNC_W-1:0]   r_func;
    logic [2:0]              r_off;
    logic                    r_we;
    logic                    r_mis;
    logic [DATA_W-1:0]       r_load;

    logic                    w_mem;
    logic                    w_we;
    logic                    w_mis;
    logic [ADDR_W-1:0]       w_addr;
    logic [MEM_FUNC_W-1:0]   w_func;
    logic [MEM_FUNC_W-1:0]   w_afunc;
    logic [2:0]              w_aoff;
    logic [DATA_W-1:0]       w_wdata;
    logic [DATA_W-1:0]       w_rdata;
    logic [7:0]              w_wmask;

    // A write wins when both enables are set, so its address is the one used
    assign w_mem  = RamReadEnableM | RamWriteEnableM;
    assign w_we   = RamWriteEnableM;
    assign w_addr = w_we ? RamWriteAddrM : RamReadAddrM;
    assign w_func = lowest_set(memFuncM);

    // Aligner sees live M fields while latching, and the latched op while the response returns
    assign w_afunc = (r_state == MEM_IDLE) ? w_func : r_func;
    assign w_aoff  = (r_state == MEM_IDLE) ? w_addr[2:0] : r_off;

    assign stallM = (r_state == MEM_IDLE) ? w_mem : (r_state != MEM_DONE);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_mis = ((w_func[MEM_LH] | w_func[MEM_LHU] | w_func[MEM_SH]) & w_addr[0]) |
                   ((w_func[MEM_LW] | w_func[MEM_LWU] | w_func[MEM_SW]) & (w_addr[1:0] != 2'b00)) |
                   ((w_func[MEM_LD] | w_func[MEM_SD]) & (w_addr[2:0] != 3'b000));
`else
    assign w_mis = 1'b0;
`endif

    mem_align u_align (
        .i_func  (w_afunc),
        .i_off   (w_aoff),
        .i_wdata (RamWriteDataM),
        .i_rdata (ram_resp_rdata),
        .o_wdata (w_wdata),
        .o_wmask (w_wmask),
        .o_rdata (w_rdata)
    );

    // Request/response FSM driving the registered RAM request and W bundle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= MEM_IDLE;
            r_func         <= '0;
            r_off          <= '0;
            r_we           <= 1'b0;
            r_mis          <= 1'b0;
            r_load         <= '0;
            ram_req_valid  <= 1'b0;
            ram_req_we     <= 1'b0;
            ram_req_addr   <= '0;
            ram_req_wdata  <= '0;
            ram_req_wmask  <= '0;
            rdWriteEnableW <= 1'b0;
            rdWriteAddrW   <= '0;
            rdWriteDataW   <= '0;
            pcW            <= '0;
            instW          <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalignW      <= 1'b0;
`endif
        end else begin
            case (r_state)
                MEM_IDLE: begin
`ifdef MEM_MISALIGN_TRAP_EN
                    misalignW <= 1'b0;
`endif
                    if (w_mem) begin
                        r_func        <= w_func;
                        r_off         <= w_addr[2:0];
                        r_we          <= w_we;
                        r_mis         <= w_mis;
                        ram_req_we    <= w_we;
                        ram_req_addr  <= {w_addr[ADDR_W-1:3], 3'b000};
                        // Loads present no write data or byte enables to the RAM
                        ram_req_wdata <= w_we ? w_wdata : '0;
                        ram_req_wmask <= w_we ? w_wmask : 8'h00;
                        ram_req_valid <= ~w_mis;
                        r_state       <= w_mis ? MEM_DONE : MEM_REQ;
                    end else begin
                        rdWriteEnableW <= rdWriteEnableM;
                        rdWriteAddrW   <= rdWriteAddrM;
                        rdWriteDataW   <= rdWriteDataM;
                        pcW            <= pcM;
                        instW          <= instM;
                    end
                end
                MEM_REQ: begin
                    if (ram_req_ready) begin
                        ram_req_valid <= 1'b0;
                        r_state       <= r_we ? MEM_DONE : MEM_RESP;
                    end
                end
                MEM_RESP: begin
                    if (ram_resp_valid) begin
                        r_load  <= w_rdata;
                        r_state <= MEM_DONE;
                    end
                end
                MEM_DONE: begin
                    rdWriteEnableW <= rdWriteEnableM & ~r_mis;
                    rdWriteAddrW   <= rdWriteAddrM;
                    rdWriteDataW   <= r_we ? rdWriteDataM : r_load;
                    pcW            <= pcM;
                    instW          <= instM;
`ifdef MEM_MISALIGN_TRAP_EN
                    misalignW      <= r_mis;
`endif
                    r_state        <= MEM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage requests, stalls and writeback
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] memFuncM = '0;
    logic        RamReadEnableM = 1'b0;
    logic        RamWriteEnableM = 1'b0;
    logic [63:0] RamReadAddrM = '0;
    logic [63:0] RamWriteAddrM = '0;
    logic [63:0] RamWriteDataM = '0;
    logic        rdWriteEnableM = 1'b0;
    logic [4:0]  rdWriteAddrM = '0;
    logic [63:0] rdWriteDataM = '0;
    logic [63:0] pcM = '0;
    logic [31:0] instM = '0;
    logic        ram_req_valid;
    logic        ram_req_ready = 1'b0;
    logic        ram_req_we;
    logic [63:0] ram_req_addr;
    logic [63:0] ram_req_wdata;
    logic [7:0]  ram_req_wmask;
    logic        ram_resp_valid = 1'b0;
    logic [63:0] ram_resp_rdata = '0;
    logic        stallM;
    logic        rdWriteEnableW;
    logic [4:0]  rdWriteAddrW;
    logic [63:0] rdWriteDataW;
    logic [63:0] pcW;
    logic [31:0] instW;
    logic        mis_w;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalignW;
    assign mis_w = misalignW;
`else
    assign mis_w = 1'b0;
`endif

    mem_stage dut (
        .clk(clk), .rst(rst), .memFuncM(memFuncM),
        .RamReadEnableM(RamReadEnableM), .RamWriteEnableM(RamWriteEnableM),
        .RamReadAddrM(RamReadAddrM), .RamWriteAddrM(RamWriteAddrM), .RamWriteDataM(RamWriteDataM),
        .rdWriteEnableM(rdWriteEnableM), .rdWriteAddrM(rdWriteAddrM), .rdWriteDataM(rdWriteDataM),
        .pcM(pcM), .instM(instM),
        .ram_req_valid(ram_req_valid), .ram_req_ready(ram_req_ready), .ram_req_we(ram_req_we),
        .ram_req_addr(ram_req_addr), .ram_req_wdata(ram_req_wdata), .ram_req_wmask(ram_req_wmask),
        .ram_resp_valid(ram_resp_valid), .ram_resp_rdata(ram_resp_rdata),
        .stallM(stallM), .rdWriteEnableW(rdWriteEnableW), .rdWriteAddrW(rdWriteAddrW),
        .rdWriteDataW(rdWriteDataW), .pcW(pcW),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalignW(misalignW),
`endif
        .instW(instW)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
    } req_t;

    typedef struct packed {
        logic        en;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        mis;
    } wb_t;

    req_t req_q[$];
    wb_t  wb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic int low_bit(input logic [10:0] f);
        for (int i = 0; i < 11; i++) if (f[i]) return i;
        return -1;
    endfunction

    function automatic int op_size(input int b);
        case (b)
            0, 4, 7: return 1;
            1, 5, 8: return 2;
            2, 6, 9: return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [7:0] model_mask(input int b, input logic [2:0] off);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++)
            if (i >= int'(off) && i < int'(off) + op_size(b)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] model_load(input int b, input logic [2:0] off, input logic [63:0] rd);
        logic [63:0] r;
        int n;
        logic s;
        r = '0;
        n = op_size(b);
        for (int j = 0; j < 8; j++)
            if (j < n && int'(off) + j < 8) r[8*j +: 8] = rd[8*(int'(off)+j) +: 8];
        s = r[8*n-1];
        if (b <= 2) for (int k = 8*n; k < 64; k++) r[k] = s;
        return r;
    endfunction

`ifdef MEM_MISALIGN_TRAP_EN
    function automatic logic model_mis(input int b, input logic [2:0] off);
        int n;
        n = op_size(b);
        return (n == 2 && off[0]) || (n == 4 && off[1:0] != 2'b00) || (n == 8 && off != 3'b000);
    endfunction
`endif

    function automatic logic [165:0] w_now();
        return {rdWriteEnableW, rdWriteAddrW, rdWriteDataW, pcW, instW};
    endfunction

    task automatic run_op(input string name, input logic [10:0] f, input logic re, input logic wr,
                          input logic [63:0] addr, input logic [63:0] data, input logic [63:0] rdata,
                          input logic rden, input int rdy_dly, input int rsp_dly);
        int b, vcnt, rcnt, stall, exp_stall;
        bit acc, done, hs, wchg;
        logic mis;
        logic [63:0] alu;
        logic [165:0] snap;
        req_t r;
        wb_t e;
        b = low_bit(f);
        vcnt = 0; rcnt = 0; stall = 0;
        acc = 0; done = 0; wchg = 0;
        mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis = model_mis(b, addr[2:0]);
`endif
        if (!mis)
            req_q.push_back('{wr, {addr[63:3], 3'b000},
                              wr ? data << {addr[2:0], 3'b000} : 64'd0,
                              wr ? model_mask(b, addr[2:0]) : 8'd0});
        alu    = {$urandom, $urandom};
        e.en   = rden & ~mis;
        e.rd   = 5'($urandom_range(1, 31));
        e.pc   = {$urandom, $urandom};
        e.inst = $urandom;
        e.mis  = mis;
        e.data = wr ? alu : model_load(b, addr[2:0], rdata);
        wb_q.push_back(e);
        exp_stall = mis ? 1 : wr ? 2 + rdy_dly : 3 + rdy_dly + rsp_dly;
        memFuncM        = f;
        RamReadEnableM  = re;
        RamWriteEnableM = wr;
        RamWriteAddrM   = wr ? addr : addr ^ 64'h105;
        RamReadAddrM    = wr ? addr ^ 64'h105 : addr;
        RamWriteDataM   = data;
        rdWriteEnableM  = rden;
        rdWriteAddrM    = e.rd;
        rdWriteDataM    = alu;
        pcM             = e.pc;
        instM           = e.inst;
        #1;
        snap = w_now();
        for (int c = 0; c < 64 && !done; c++) begin
            if (stallM) stall++;
            else done = 1;
            if (w_now() !== snap) wchg = 1;
            if (ram_req_valid) begin
                n_chk++;
                if (req_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s req: got request %h where none is expected", name,
                             {ram_req_we, ram_req_addr, ram_req_wdata, ram_req_wmask});
                end else if ({ram_req_we, ram_req_addr, ram_req_wdata, ram_req_wmask} !== req_q[0]) begin
                    n_fail++;
                    $display("FAIL %s req: got %h expected %h", name,
                             {ram_req_we, ram_req_addr, ram_req_wdata, ram_req_wmask}, req_q[0]);
                end
                ram_req_ready = (vcnt >= rdy_dly);
                vcnt++;
            end else begin
                ram_req_ready = 1'b0;
            end
            ram_resp_valid = (acc && !wr) ? (rcnt >= rsp_dly) : !acc;
            ram_resp_rdata = (acc && !wr && rcnt >= rsp_dly) ? rdata : ~rdata;
            if (acc && !wr) rcnt++;
            hs = ram_req_valid && ram_req_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                acc = 1;
                if (req_q.size() != 0) r = req_q.pop_front();
            end
        end
        ram_req_ready  = 1'b0;
        ram_resp_valid = 1'b0;
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: stallM still %b after 64 cycles, required 0", name, stallM);
        end
        n_chk++;
        if (stall != exp_stall) begin
            n_fail++;
            $display("FAIL %s stall: got %0d stalled cycles expected %0d", name, stall, exp_stall);
        end
        n_chk++;
        if (wchg) begin
            n_fail++;
            $display("FAIL %s w_hold: W changed before DONE (got 1 expected 0)", name);
        end
        n_chk++;
        if (req_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s req_issued: %0d requests left unaccepted, expected 0", name, req_q.size());
            req_q.delete();
        end
        e = wb_q.pop_front();
        n_chk++;
        if ({rdWriteEnableW, rdWriteAddrW, pcW, instW, mis_w} !== {e.en, e.rd, e.pc, e.inst, e.mis}) begin
            n_fail++;
            $display("FAIL %s w_ctl: got %h expected %h", name,
                     {rdWriteEnableW, rdWriteAddrW, pcW, instW, mis_w}, {e.en, e.rd, e.pc, e.inst, e.mis});
        end
        if (!mis) begin
            n_chk++;
            if (rdWriteDataW !== e.data) begin
                n_fail++;
                $display("FAIL %s w_data: got %h expected %h", name, rdWriteDataW, e.data);
            end
        end
        memFuncM        = '0;
        RamReadEnableM  = 1'b0;
        RamWriteEnableM = 1'b0;
        rdWriteEnableM  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({ram_req_valid, ram_req_we, ram_req_addr, ram_req_wdata, ram_req_wmask, stallM} !== '0) begin
            n_fail++;
            $display("FAIL reset_req: got %h expected 0",
                     {ram_req_valid, ram_req_we, ram_req_addr, ram_req_wdata, ram_req_wmask, stallM});
        end
        n_chk++;
        if ({w_now(), mis_w} !== '0) begin
            n_fail++;
            $display("FAIL reset_w: got %h expected 0", {w_now(), mis_w});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store();
        run_op("sd", 11'h400, 1'b0, 1'b1, 64'h1000, 64'h1122334455667788, 64'h0, 1'b0, 0, 0);
        run_op("sb", 11'h080, 1'b0, 1'b1, 64'h1005, 64'hAB, 64'h0, 1'b0, 0, 0);
        run_op("sh", 11'h100, 1'b0, 1'b1, 64'h40A2, 64'hBEEF, 64'h0, 1'b0, 1, 0);
    endtask

    task automatic test_load();
        run_op("lb", 11'h001, 1'b1, 1'b0, 64'h1003, 64'h0, 64'h00000000F0000000, 1'b1, 0, 0);
        run_op("lbu", 11'h010, 1'b1, 1'b0, 64'h1003, 64'h0, 64'h00000000F0000000, 1'b1, 0, 0);
        run_op("lhu", 11'h020, 1'b1, 1'b0, 64'h5006, 64'h0, 64'h8001_0000_0000_0000, 1'b1, 0, 1);
        run_op("ld", 11'h008, 1'b1, 1'b0, 64'h6000, 64'h0, 64'hFEDCBA9876543210, 1'b1, 0, 0);
    endtask

    task automatic test_delay();
        run_op("lw_delay", 11'h004, 1'b1, 1'b0, 64'h2004, 64'h0, 64'h89ABCDEF_01234567, 1'b1, 3, 2);
    endtask

    task automatic test_priority();
        run_op("multi_hot", 11'h007, 1'b1, 1'b0, 64'h7001, 64'h0, 64'h0000_0000_0000_8000, 1'b1, 0, 0);
        run_op("rd_and_wr", 11'h200, 1'b1, 1'b1, 64'h7004, 64'hCAFEF00D, 64'h0, 1'b0, 0, 0);
    endtask

    task automatic test_misalign();
        run_op("sw_mis", 11'h200, 1'b0, 1'b1, 64'h1006, 64'h11223344, 64'h0, 1'b0, 0, 0);
        run_op("lw_mis", 11'h004, 1'b1, 1'b0, 64'h2002, 64'h0, 64'h8877665544332211, 1'b1, 0, 0);
        run_op("lw_edge", 11'h004, 1'b1, 1'b0, 64'h2006, 64'h0, 64'h8877665544332211, 1'b1, 0, 0);
        run_op("ld_mis", 11'h008, 1'b1, 1'b0, 64'h3005, 64'h0, 64'h0123456789ABCDEF, 1'b1, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            int b;
            logic wr;
            b  = $urandom_range(0, 10);
            wr = (b >= 7);
            run_op("b2b", 11'(1 << b), !wr, wr, {48'd0, 16'($urandom)}, {$urandom, $urandom},
                   {$urandom, $urandom}, !wr, $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_in_resp();
        memFuncM       = 11'h004;
        RamReadEnableM = 1'b1;
        RamReadAddrM   = 64'h2004;
        ram_req_ready  = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (ram_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_resp_req: valid got %b expected 1", ram_req_valid);
        end
        @(posedge clk);
        #1;
        ram_req_ready = 1'b0;
        n_chk++;
        if ({ram_req_valid, stallM} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_resp_wait: valid/stall got %b expected 01", {ram_req_valid, stallM});
        end
        rst            = 1'b1;
        memFuncM       = '0;
        RamReadEnableM = 1'b0;
        rdWriteEnableM = 1'b1;
        rdWriteAddrM   = 5'd9;
        rdWriteDataM   = 64'h777;
        pcM            = '0;
        instM          = '0;
        @(posedge clk);
        #1;
        n_chk++;
        if ({ram_req_valid, ram_req_we, ram_req_addr, ram_req_wdata, ram_req_wmask, stallM, w_now()} !== '0) begin
            n_fail++;
            $display("FAIL rst_resp_clear: got %h expected 0",
                     {ram_req_valid, ram_req_we, ram_req_addr, ram_req_wdata, ram_req_wmask, stallM, w_now()});
        end
        rst            = 1'b0;
        ram_resp_valid = 1'b1;
        ram_resp_rdata = 64'hDEADBEEFDEADBEEF;
        @(posedge clk);
        #1;
        ram_resp_valid = 1'b0;
        n_chk++;
        if ({rdWriteEnableW, rdWriteAddrW, rdWriteDataW, ram_req_valid, stallM} !== {1'b1, 5'd9, 64'h777, 2'b00}) begin
            n_fail++;
            $display("FAIL rst_resp_late: got %h expected %h",
                     {rdWriteEnableW, rdWriteAddrW, rdWriteDataW, ram_req_valid, stallM}, {1'b1, 5'd9, 64'h777, 2'b00});
        end
        rdWriteEnableM = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_delay();
        test_priority();
        test_misalign();
        test_back_to_back();
        test_reset_in_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
